uart_link_ctl: RTL and testbench

Round-robin transmit scheduler and retransmission controller for the UART link. It shares one UART transmitter between `NREQ` requesters and launches one `size`-bit frame at a time. After each frame it watches the receiver's `Flag_Rx` parity-error request and, if raised, resends the same word up to `MAX_RETRY` times. It sits between the requesting clients and the UART Tx/Rx pair, on the baud clock domain.

---
 rtl/uart_link_ctl.sv | 191 +++++++++++++++++++
 tb/tb_uart_link_ctl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_link_ctl.sv
// rtl/uart_link_ctl.sv - round-robin UART transmit scheduler with parity-error retransmission
module uart_link_ctl #(
    parameter int NREQ       = 4,
    parameter int size       = 32,
    parameter int MAX_RETRY  = 3,
    parameter int ACK_WIN    = 40,
    parameter int TX_TIMEOUT = 64
) (
    input  logic                 CLK_Baudin,
    input  logic                 RstCtl_n,
    input  logic [NREQ-1:0]      Req,
    input  logic [NREQ*size-1:0] ReqData,
    input  logic                 DoneTx,
    input  logic                 Flag_Rx,
    output logic [NREQ-1:0]      Grant,
    output logic [size-1:0]      TxData,
    output logic                 TxStart,
    output logic [NREQ-1:0]      Done,
    output logic [NREQ-1:0]      Fail,
    output logic                 Busy
);

    localparam int PW = $clog2(NREQ);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int WW = $clog2(ACK_WIN + 1);
    localparam int TW = $clog2(TX_TIMEOUT + 1);

    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [WW-1:0] WIN_MAX   = WW'(ACK_WIN);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TX_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARB      = 3'd1,
        S_LOAD     = 3'd2,
        S_SEND     = 3'd3,
        S_WAIT_ACK = 3'd4,
        S_COMPLETE = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [RW-1:0]   retry_cnt_q, retry_cnt_d;
    logic [WW-1:0]   win_cnt_q, win_cnt_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [size-1:0] txdata_q, txdata_d;
    logic            txstart_q, txstart_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] fail_q, fail_d;
    logic            busy_q, busy_d;

    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic            attempt_err;

    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) sum = sum - NREQ;
        return sum[PW-1:0];
    endfunction

    // First requester at or above ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && Req[rr_index(ptr_q, i)]) begin
                win_found = 1'b1;
                win_idx   = rr_index(ptr_q, i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        retry_cnt_d = retry_cnt_q;
        win_cnt_d   = win_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        grant_d     = grant_q;
        txdata_d    = txdata_q;
        txstart_d   = 1'b0;
        done_d      = '0;
        fail_d      = '0;
        attempt_err = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|Req) state_d = S_ARB;
            end
            S_ARB: begin
                if (win_found) begin
                    grant_d     = NREQ'(1) << win_idx;
                    owner_d     = win_idx;
                    ptr_d       = rr_index(win_idx, 1);
                    retry_cnt_d = '0;
                    state_d     = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                // Retries resend the word captured on the first attempt
                if (retry_cnt_q == '0) txdata_d = ReqData[int'(owner_q)*size +: size];
                txstart_d = 1'b1;
                tmo_cnt_d = '0;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + 1'b1;
                // A DoneTx level left over from the previous frame is ignored in the first SEND cycle
                if (DoneTx && (tmo_cnt_q != '0)) begin
                    win_cnt_d = '0;
                    state_d   = S_WAIT_ACK;
                end else if (tmo_cnt_d == TMO_MAX) begin
                    attempt_err = 1'b1;
                end
            end
            S_WAIT_ACK: begin
                if (win_cnt_q != WIN_MAX) win_cnt_d = win_cnt_q + 1'b1;
                if (Flag_Rx) begin
                    attempt_err = 1'b1;
                end else if (win_cnt_d == WIN_MAX) begin
                    done_d  = grant_q;
                    state_d = S_COMPLETE;
                end
            end
            S_COMPLETE: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (attempt_err) begin
            if (retry_cnt_q < RETRY_MAX) begin
                retry_cnt_d = retry_cnt_q + 1'b1;
                state_d     = S_LOAD;
            end else begin
                fail_d  = grant_q;
                state_d = S_COMPLETE;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK_Baudin) begin
        if (!RstCtl_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            retry_cnt_q <= '0;
            win_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            grant_q     <= '0;
            txdata_q    <= '0;
            txstart_q   <= 1'b0;
            done_q      <= '0;
            fail_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            retry_cnt_q <= retry_cnt_d;
            win_cnt_q   <= win_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            grant_q     <= grant_d;
            txdata_q    <= txdata_d;
            txstart_q   <= txstart_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            busy_q      <= busy_d;
        end
    end

    assign Grant   = grant_q;
    assign TxData  = txdata_q;
    assign TxStart = txstart_q;
    assign Done    = done_q;
    assign Fail    = fail_q;
    assign Busy    = busy_q;

endmodule

// File: tb/tb_uart_link_ctl.sv
// tb/tb_uart_link_ctl.sv - table-driven bench for uart_link_ctl with a simple Tx/Rx model
module tb_uart_link_ctl;

    localparam int ACK_WIN    = 40;
    localparam int TX_TIMEOUT = 64;

    logic         clk;
    logic         RstCtl_n;
    logic [3:0]   Req;
    logic [127:0] ReqData;
    logic         DoneTx;
    logic         Flag_Rx;
    logic [3:0]   Grant;
    logic [31:0]  TxData;
    logic         TxStart;
    logic [3:0]   Done;
    logic [3:0]   Fail;
    logic         Busy;

    uart_link_ctl dut (
        .CLK_Baudin (clk),
        .RstCtl_n   (RstCtl_n),
        .Req        (Req),
        .ReqData    (ReqData),
        .DoneTx     (DoneTx),
        .Flag_Rx    (Flag_Rx),
        .Grant      (Grant),
        .TxData     (TxData),
        .TxStart    (TxStart),
        .Done       (Done),
        .Fail       (Fail),
        .Busy       (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          idx;
        int          lat;
        int          skip;
        int          nflags;
        int          off;
        bit          drop;
        logic [3:0]  raise;
        bit          mutate;
        int          starts;
        bit          exp_done;
        int          retry;
    } vec_t;

    vec_t vt[10];

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0;
    int done_at, flag_at;
    int tx_lat, tx_skip, nflags, flag_off;
    int n_start, data_bad, grant_bad, oh_bad;
    int start_cyc[8];
    int done_cyc, last_dt;
    logic [31:0] exp_data;
    logic [3:0]  exp_grant, raise_bits, done_seen, fail_seen;
    bit chk_data, drop_mid, mutate, auto_drop;
    logic [3:0] rr_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: outputs sampled 1 time unit after the edge, Tx/Rx model and requesters react
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (TxStart) begin
            if (n_start < 8) start_cyc[n_start] = cyc;
            n_start++;
            if (chk_data && TxData !== exp_data) data_bad++;
            if (tx_skip > 0) tx_skip--;
            else if (tx_lat > 0) done_at = cyc + tx_lat;
            if (drop_mid) Req = (Req & ~exp_grant) | raise_bits;
            if (mutate) ReqData = ~ReqData;
        end
        DoneTx = (cyc == done_at);
        if (DoneTx) begin
            last_dt = cyc;
            if (nflags > 0) begin
                flag_at = cyc + 1 + flag_off;
                nflags--;
            end
        end
        Flag_Rx = (cyc == flag_at);
        if (exp_grant != 4'b0 && Grant != 4'b0 && Grant !== exp_grant) grant_bad++;
        if ($countones(Grant | Done | Fail) > 1) oh_bad++;
        if ((Done | Fail) != 4'b0) begin
            done_seen |= Done;
            fail_seen |= Fail;
            done_cyc = cyc;
            if (Done != 4'b0) rr_q.push_back(Done);
            if (auto_drop) Req = 4'b0;
        end
    endtask

    task automatic clear_mon();
        n_start = 0; data_bad = 0; grant_bad = 0; oh_bad = 0;
        done_seen = '0; fail_seen = '0; done_cyc = 0; last_dt = 0;
        done_at = -1; flag_at = -1; tx_skip = 0; nflags = 0; flag_off = 0;
        drop_mid = 0; mutate = 0; raise_bits = '0;
        for (int i = 0; i < 8; i++) start_cyc[i] = 0;
    endtask

    task automatic reset_dut(input int n);
        RstCtl_n = 1'b0;
        for (int i = 0; i < n; i++) step();
        RstCtl_n = 1'b1;
        done_at = -1;
        flag_at = -1;
    endtask

    task automatic fill_data(input logic [31:0] base);
        for (int i = 0; i < 4; i++) ReqData[i*32 +: 32] = base + 32'(i) * 32'h1111_1111;
    endtask

    task automatic wait_end(input string tag);
        int k;
        k = 0;
        while ((done_seen | fail_seen) == 4'b0 && k < 1500) begin
            step();
            k++;
        end
        chk({tag, "_finished"}, ((done_seen | fail_seen) != 4'b0), 1);
    endtask

    task automatic run_vec(input int n, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", n);
        clear_mon();
        fill_data(v.data);
        exp_data   = v.data + 32'(v.idx) * 32'h1111_1111;
        exp_grant  = 4'b0001 << v.idx;
        tx_lat     = v.lat;
        tx_skip    = v.skip;
        nflags     = v.nflags;
        flag_off   = v.off;
        drop_mid   = v.drop;
        raise_bits = v.raise;
        mutate     = v.mutate;
        chk_data   = 1;
        auto_drop  = 1;
        Req        = v.req;
        wait_end(tag);
        chk({tag, "_starts"}, n_start, v.starts);
        chk({tag, "_done"}, done_seen, v.exp_done ? exp_grant : 4'b0);
        chk({tag, "_fail"}, fail_seen, v.exp_done ? 4'b0 : exp_grant);
        chk({tag, "_txdata"}, data_bad, 0);
        chk({tag, "_grant_owner"}, grant_bad, 0);
        chk({tag, "_onehot"}, oh_bad, 0);
        if (v.exp_done) chk({tag, "_done_lat"}, done_cyc - last_dt, ACK_WIN + 1);
        if (v.skip > 0) chk({tag, "_tmo_gap"}, start_cyc[1] - start_cyc[0], TX_TIMEOUT + 1);
        step();
        step();
        chk({tag, "_retry_cnt"}, dut.retry_cnt_q, v.retry);
        chk({tag, "_idle_busy"}, {Busy, Grant}, 5'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n0;

        //       req      data          idx lat skip nfl off drop raise   mut starts done retry
        vt[0] = '{4'b0010, 32'hA5A5_0F0F, 1, 40, 0,  0,  0,  0, 4'b0000, 0,  1,    1,   0};
        vt[1] = '{4'b0010, 32'h1357_9BDF, 1, 40, 0,  2,  5,  0, 4'b0000, 1,  3,    1,   2};
        vt[2] = '{4'b1001, 32'hCAFE_0001, 3, 20, 0,  4,  3,  0, 4'b0000, 0,  4,    0,   3};
        vt[3] = '{4'b1001, 32'h0BAD_F00D, 0, 10, 0,  0,  0,  0, 4'b0000, 0,  1,    1,   0};
        vt[4] = '{4'b0101, 32'h5555_AAAA, 2, 60, 0,  1,  0,  0, 4'b0000, 0,  2,    1,   1};
        vt[5] = '{4'b0011, 32'h0000_0001, 0,  1, 0,  0,  0,  0, 4'b0000, 0,  1,    1,   0};
        vt[6] = '{4'b0100, 32'hDEAD_BEEF, 2, 30, 0,  1, 39,  0, 4'b0000, 0,  2,    1,   1};
        vt[7] = '{4'b0100, 32'hFEED_FACE, 2, 30, 0,  1, 40,  0, 4'b0000, 0,  1,    1,   0};
        vt[8] = '{4'b0010, 32'h2468_ACE0, 1, 15, 0,  0,  0,  1, 4'b0001, 0,  1,    1,   0};
        vt[9] = '{4'b0001, 32'h7777_1234, 0, 40, 1,  0,  0,  0, 4'b0000, 0,  2,    1,   1};

        RstCtl_n = 1'b0; Req = '0; ReqData = '0; DoneTx = 1'b0; Flag_Rx = 1'b0;
        exp_grant = '0; exp_data = '0; chk_data = 0; auto_drop = 0; tx_lat = 0;
        clear_mon();

        reset_dut(3);
        chk("reset_grant", Grant, 4'b0);
        chk("reset_pulses", {TxStart, Done, Fail}, 9'b0);
        chk("reset_busy", Busy, 1'b0);
        chk("reset_txdata", TxData, 32'b0);
        step();

        // Request-to-launch latency
        clear_mon();
        fill_data(32'h1234_5678);
        exp_data  = 32'h1234_5678 + 32'h2222_2222;
        exp_grant = 4'b0100;
        chk_data  = 1;
        auto_drop = 1;
        tx_lat    = 40;
        Req = 4'b0100;
        step();
        chk("lat_arb_busy", {Busy, Grant}, {1'b1, 4'b0000});
        step();
        chk("lat_grant", {Grant, TxStart}, {4'b0100, 1'b0});
        step();
        chk("lat_txstart", {TxStart, TxData}, {1'b1, exp_data});
        wait_end("lat");
        chk("lat_done", done_seen, 4'b0100);
        step();
        step();

        reset_dut(1);
        step();
        for (int i = 0; i < 10; i++) run_vec(i, vt[i]);

        // Round-robin with all requesters held, then a reset in the middle of SEND
        reset_dut(1);
        clear_mon();
        exp_grant = '0; chk_data = 0; auto_drop = 0; tx_lat = 5;
        rr_q.delete();
        Req = 4'b1111;
        k = 0;
        while (rr_q.size() < 5 && k < 2000) begin step(); k++; end
        chk("rr_count", rr_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < rr_q.size()) chk($sformatf("rr_order%0d", i), rr_q[i], 4'b0001 << (i % 4));

        n0 = n_start;
        k = 0;
        while (n_start == n0 && k < 100) begin step(); k++; end
        chk("rr_next_start", n_start, n0 + 1);
        step();
        RstCtl_n = 1'b0;
        step();
        chk("midsend_reset_grant_busy", {Grant, Busy}, 5'b0);
        chk("midsend_reset_pulses", {TxStart, Done, Fail}, 9'b0);
        RstCtl_n = 1'b1;
        done_at = -1;
        flag_at = -1;
        rr_q.delete();
        k = 0;
        while (rr_q.size() < 2 && k < 1000) begin step(); k++; end
        chk("rr_restart_count", rr_q.size(), 2);
        if (rr_q.size() >= 2) begin
            chk("rr_restart0", rr_q[0], 4'b0001);
            chk("rr_restart1", rr_q[1], 4'b0010);
        end
        chk("rr_onehot", oh_bad, 0);

        Req = 4'b0;
        for (int i = 0; i < 60; i++) step();
        chk("final_idle", {Busy, Grant}, 5'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
